// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver: scan-state
// encoding, the active-high hex glyph table and the pin polarity.
package seg7_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } scan_state_t;

  // Bit order abcdefg (a = bit 6); entry 15 is listed first.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Board drives common-anode digits: a pin at this level is unlit/off.
  localparam logic ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to seven-segment glyph decoder, active-high output
// in abcdefg order.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures CPU result/carry/zero flags and scans them across a 3-digit
// common-anode display. Optional carry blink: define SEG7_CARRY_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] rezult,
  input  logic       carry,
  input  logic       z,
  output logic       AN0,
  output logic       AN1,
  output logic       AN2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       fp,
  output logic       g,
  output logic       dp
);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  scan_state_t      state, state_next;
  logic [3:0]       val_q;
  logic             c_q, z_q;
  logic [3:0]       digit_val;
  logic [2:0]       an_sel;
  logic [6:0]       glyph;
  logic             blink;
  logic [2:0]       an_q;
  logic [6:0]       seg_q;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else if (load) begin
      val_q <= rezult;
      c_q   <= carry;
      z_q   <= z;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DIG0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        DIG0:    state_next = DIG1;
        DIG1:    state_next = DIG2;
        default: state_next = DIG0;
      endcase
    end
  end

  always_comb begin
    digit_val = val_q;
    an_sel    = 3'b001;
    case (state)
      DIG1: begin
        digit_val = {3'b000, c_q};
        an_sel    = 3'b010;
      end
      DIG2: begin
        digit_val = {3'b000, z_q};
        an_sel    = 3'b100;
      end
      default: ;
    endcase
  end

  hex_to_seg7 u_dec (
    .hex (digit_val),
    .seg (glyph)
  );

`ifdef SEG7_CARRY_BLINK_EN
  logic [2:0] frame;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      frame <= '0;
    else if (tick && state == DIG2) frame <= frame + 3'd1;
  end

  assign blink = c_q & frame[2];
`else
  assign blink = 1'b0;
`endif

  // Registering with tick forces the ghost-blank cycle while the state
  // register moves to the next digit on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_q  <= {3{ACTIVE_LOW}};
      seg_q <= {7{ACTIVE_LOW}};
    end else if (tick || blink) begin
      an_q  <= {3{ACTIVE_LOW}};
      seg_q <= {7{ACTIVE_LOW}};
    end else begin
      an_q  <= an_sel ^ {3{ACTIVE_LOW}};
      seg_q <= glyph ^ {7{ACTIVE_LOW}};
    end
  end

  assign {AN2, AN1, AN0}         = an_q;
  assign {a, b, c, d, e, fp, g}  = seg_q;
  assign dp                      = ACTIVE_LOW;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the CPU datapath outputs `rezult[3:0]`, `carry` and `z`.
- Captures those outputs on a load strobe and time-multiplexes them onto the board's 3-digit common-anode seven-segment display: AN0 shows the result in hex, AN1 the carry flag, AN2 the zero flag.
- Owns the refresh prescaler, the digit-scan state machine and the registered segment/anode outputs.

Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected; legal range 2..65535.
- `CNT_W`, default 16: prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- `clock`  input  1  system clock.
- `reset`  input  1  asynchronous reset, active-high.
- `load`  input  1  capture strobe; samples `rezult`/`carry`/`z` on the rising edge of `clock`.
- `rezult`  input  4  ALU result from the CPU.
- `carry`  input  1  carry flag from the CPU.
- `z`  input  1  zero flag from the CPU.
- `AN0`, `AN1`, `AN2`  output  1 each  digit enables, active-low.
- `a`, `b`, `c`, `d`, `e`, `fp`, `g`  output  1 each  segments a–f,g, active-low (`fp` = segment f).
- `dp`  output  1  decimal point, active-low.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, named `reset`; `clock` is the only clock.
- Reset values:
  - AN0..AN2 = 1 (all digits off).
  - a..g, `fp`, `dp` = 1 (all segments dark).
  - Prescaler = 0; scan state = DIG0.
  - Captured regs `val_q` = 0, `c_q` = 0, `z_q` = 0.
- Capture:
  - When `load` = 1 at a clock edge: `val_q` <= `rezult`, `c_q` <= `carry`, `z_q` <= `z`.
  - With `load` held high, capture happens every cycle.
  - With `load` low, the captured values hold indefinitely.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - `tick` is asserted on the cycle the count equals REFRESH_DIV-1.
- Scan FSM, states DIG0 -> DIG1 -> DIG2 -> DIG0:
  - Advances only on `tick`; never skips a state.
  - A full refresh period is 3*REFRESH_DIV cycles.
- Digit content:
  - DIG0: hex glyph of `val_q`.
  - DIG1: glyph `0`/`1` for `c_q`.
  - DIG2: glyph `0`/`1` for `z_q`.
  - `dp` stays dark (1) in all states.
- Hex glyphs (abcdefg, 1 = lit before inversion):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Output timing:
  - Anode and segment outputs are registered, one cycle after the FSM state and captured values.
  - On the cycle after each `tick`, all anodes are driven 1 (ghost-blanking cycle). The new anode asserts on the cycle after that.
  - Net latency: a new capture is visible on the segments at most 3*REFRESH_DIV+2 cycles after `load`.
- Exactly one anode is 0 at any time, except during reset and blanking cycles.
- If `load` coincides with `tick`, the newly captured value is used for the next digit displayed.
- Reset asserted mid-scan: all outputs go dark immediately (asynchronously). Scanning resumes at DIG0 with count 0 on the first edge after release.

Optional Feature:
- Macro `SEG7_CARRY_BLINK_EN`.
- Defined:
  - A 3-bit frame counter increments each time the FSM wraps DIG2 -> DIG0.
  - While `c_q` = 1, all anodes are forced to 1 whenever frame-counter bit 2 is 1 (whole display blinks, 50 % duty).
  - The frame counter resets to 0.
- Undefined: no frame counter; display is steady regardless of `c_q`.

Decomposition:
- Package `seg7_pkg`:
  - Scan-state encoding (DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2).
  - 16-entry hex glyph constant table.
  - Active-low polarity constant.
- Sub-module `hex_to_seg7`: combinational 4-bit to 7-bit active-high glyph decoder. It is instantiated once; inversion is done in the top-level output register.

Test Plan (`REFRESH_DIV` = 4):
1. Reset asserted for 3 cycles, then released → all outputs 1 during reset; first AN0 = 0 appears 2 cycles after release, with glyph 0 (a..fp = 0, g = 1).
2. `load` = 1 for one cycle with `rezult` = 4'hA, `carry` = 1, `z` = 0 → DIG0 shows A (g = 0, d = 1), DIG1 shows 1, DIG2 shows 0; anode order AN0, AN1, AN2 repeating every 12 cycles.
3. Check each `tick` → exactly one all-anodes-high cycle; the active-low sum of AN0..AN2 never drops below 2.
4. Sweep `rezult` 0..F via `load` → DIG0 segments match the glyph table for all 16 values.
5. `load` on the same edge as `tick` with `rezult` = 4'h3 → the next displayed DIG0 (after wrap) shows 3.
6. With `SEG7_CARRY_BLINK_EN` defined, `carry` = 1 captured → anodes stay all-high for 4 full frames out of every 8 (48 of 96 cycles); with `carry` = 0 → no blanking beyond tick cycles.
